// File: rtl/clock_strobe_gen_if.sv
// Control and strobe-output bundle for clock_strobe_gen.
// The master side writes increments and requests resyncs; the slave side
// (the generator) drives the run flag and the per-channel strobes/squares.
interface clock_strobe_gen_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 24
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [ACC_W-1:0]  wr_inc;
  logic              resync;
  logic              running;
  logic [NUM_CH-1:0] strobe;
  logic [NUM_CH-1:0] square;

  modport master (
    output wr_en, wr_ch, wr_inc, resync,
    input  running, strobe, square
  );

  modport slave (
    input  wr_en, wr_ch, wr_inc, resync,
    output running, strobe, square
  );
endinterface

// File: rtl/clock_strobe_gen.sv
// Lock-supervised multi-channel fractional clock-enable generator.
// Waits for the PLL lock flag to be stable for SETTLE_CYCLES, then runs
// one phase accumulator per channel; each wrap yields a one-cycle strobe
// and the accumulator MSB gives a ~50 % square wave at the same rate.
module clock_strobe_gen #(
  parameter int        NUM_CH        = 4,
  parameter int        ACC_W         = 24,
  parameter int        SETTLE_CYCLES = 1024,
  parameter bit [31:0] INC_RESET     = 32'd0
) (
  input  logic               clock_in,
  input  logic               resetb,
  input  logic               locked,
  clock_strobe_gen_if.slave  bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               sync1, locked_s;
  logic               running_q;
  logic [ACC_W-1:0]   acc [NUM_CH];
  logic [ACC_W-1:0]   inc [NUM_CH];
  logic [ACC_W:0]     sum [NUM_CH];
  logic [NUM_CH-1:0]  strobe_q, square_q;
  logic               advance;

  assign bus.running = running_q;
  assign bus.strobe  = strobe_q;
  assign bus.square  = square_q;

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= locked;
      locked_s <= sync1;
    end
  end

  // State register, settle counter and registered run flag.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      running_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      running_q <= (state_nxt == RUN);
    end
  end

  // Next-state logic; loss of lock overrides every other transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        if (cnt == CNT_LAST) state_nxt = RUN;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = WAIT_LOCK;
      end
    endcase
    if (!locked_s) state_nxt = WAIT_LOCK;
  end

  // Accumulators only advance when RUN is both current and next state,
  // so entering and leaving RUN both clear the datapath.
  assign advance = (state == RUN) && (state_nxt == RUN) && !bus.resync;

  // Per-channel wrap-detecting add using the currently stored increment.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
    end
  end

  // Phase accumulators and registered strobe/square outputs.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      for (int unsigned i = 0; i < NUM_CH; i++) acc[i] <= '0;
      strobe_q <= '0;
      square_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (advance) begin
          acc[i]      <= sum[i][ACC_W-1:0];
          strobe_q[i] <= sum[i][ACC_W];
          square_q[i] <= sum[i][ACC_W-1];
        end else begin
          acc[i]      <= '0;
          strobe_q[i] <= 1'b0;
          square_q[i] <= 1'b0;
        end
      end
    end
  end

  // Increment registers; out-of-range channel indices match no channel.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      for (int unsigned i = 0; i < NUM_CH; i++) inc[i] <= INC_RESET[ACC_W-1:0];
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (bus.wr_en && (bus.wr_ch == CH_W'(i))) inc[i] <= bus.wr_inc;
      end
    end
  end
endmodule

// File: tb/tb_clock_strobe_gen.sv
// Self-checking bench for clock_strobe_gen: a cycle model pushes expected
// {running, strobe, square} each edge, a checker pops and compares, and a
// directed sequence checks lock timing, rates, collisions and reset.
module tb_clock_strobe_gen;
  localparam int NUM_CH = 3;
  localparam int ACC_W  = 8;
  localparam int SETTLE = 8;
  localparam int MOD    = 1 << ACC_W;
  localparam int RUN_AT = SETTLE + 1;

  logic clock_in = 1'b0;
  logic resetb;
  logic locked;

  int n_checks = 0;
  int n_errors = 0;

  clock_strobe_gen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) bus ();

  clock_strobe_gen #(
    .NUM_CH       (NUM_CH),
    .ACC_W        (ACC_W),
    .SETTLE_CYCLES(SETTLE),
    .INC_RESET    (32'd0)
  ) dut (
    .clock_in(clock_in),
    .resetb  (resetb),
    .locked  (locked),
    .bus     (bus)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  int                m_hi = 0;
  logic              m_s1 = 1'b0, m_s2 = 1'b0;
  int                m_acc [NUM_CH];
  int                m_inc [NUM_CH];
  logic [NUM_CH-1:0] m_st = '0, m_sq = '0;
  logic [2*NUM_CH:0] exp_q [$];

  task automatic model_reset();
    m_hi = 0;
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    m_st = '0;
    m_sq = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_acc[i] = 0;
      m_inc[i] = 0;
    end
  endtask

  initial model_reset();

  always @(negedge resetb) model_reset();

  always @(posedge clock_in) begin
    bit run_old, run_new;
    int s;
    if (!resetb) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      run_old = (m_hi >= RUN_AT);
      if (m_s2) begin
        if (m_hi < RUN_AT) m_hi++;
      end else begin
        m_hi = 0;
      end
      run_new = (m_hi >= RUN_AT);
      m_s2 = m_s1;
      m_s1 = locked;
      for (int i = 0; i < NUM_CH; i++) begin
        if (run_old && run_new && !bus.resync) begin
          s        = m_acc[i] + m_inc[i];
          m_st[i]  = (s >= MOD);
          m_acc[i] = s % MOD;
          m_sq[i]  = (m_acc[i] >= MOD / 2);
        end else begin
          m_acc[i] = 0;
          m_st[i]  = 1'b0;
          m_sq[i]  = 1'b0;
        end
      end
      if (bus.wr_en && (int'(bus.wr_ch) < NUM_CH)) m_inc[bus.wr_ch] = int'(bus.wr_inc);
      exp_q.push_back({run_new, m_st, m_sq});
    end
  end

  always @(posedge clock_in) begin
    logic [2*NUM_CH:0] e;
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("sb", int'({bus.running, bus.strobe, bus.square}), int'(e));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic write_inc(input int ch, input int val);
    @(negedge clock_in);
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 2'(ch);
    bus.wr_inc = 8'(val);
    @(negedge clock_in);
    bus.wr_en  = 1'b0;
  endtask

  task automatic do_resync();
    @(negedge clock_in);
    bus.resync = 1'b1;
    @(negedge clock_in);
    bus.resync = 1'b0;
  endtask

  task automatic wait_running(output int edges);
    edges = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clock_in);
      #1;
      if (bus.running) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic check_ch0_pattern(input string tag, input int cycles);
    int sq_tab [4] = '{0, 1, 1, 0};
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clock_in);
      #1;
      check({tag, "_sq0"}, int'(bus.square[0]), sq_tab[(k - 1) % 4]);
      check({tag, "_st0"}, int'(bus.strobe[0]), (k % 4 == 0) ? 1 : 0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int edges, n1, n2, nall;
    int pos [4];
    resetb     = 1'b0;
    locked     = 1'b0;
    bus.wr_en  = 1'b0;
    bus.wr_ch  = '0;
    bus.wr_inc = '0;
    bus.resync = 1'b0;

    repeat (2) @(posedge clock_in);
    #1;
    check("rst_running", int'(bus.running), 0);
    check("rst_outs", int'({bus.strobe, bus.square}), 0);

    @(negedge clock_in);
    resetb = 1'b1;
    write_inc(0, 64);
    write_inc(1, 3);
    write_inc(2, 0);

    // basic lock sequence
    locked = 1'b1;
    wait_running(edges);
    check("lock_rise", edges, SETTLE + 3);

    // 64/256 pattern on channel 0
    check_ch0_pattern("pat", 8);

    // fractional rate on channel 1, silence on channel 2
    do_resync();
    n1 = 0;
    n2 = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clock_in);
      #1;
      if (bus.strobe[1]) begin
        if (n1 < 4) pos[n1] = k;
        n1++;
      end
      if (bus.strobe[2] || bus.square[2]) n2++;
      if (k == 256) check("frac_cnt256", n1, 3);
    end
    check("frac_first", pos[0], 86);
    check("frac_gap1", pos[1] - pos[0], 85);
    check("frac_gap2", pos[2] - pos[1], 85);
    check("frac_gap3", pos[3] - pos[2], 86);
    check("ch2_quiet", n2, 0);

    // write on the same edge as an add: old increment used for that add
    do_resync();
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 2'd0;
    bus.wr_inc = 8'd128;
    @(posedge clock_in);
    #1;
    check("wcol_sq_a", int'(bus.square[0]), 0);
    check("wcol_st_a", int'(bus.strobe[0]), 0);
    @(negedge clock_in);
    bus.wr_en = 1'b0;
    @(posedge clock_in);
    #1;
    check("wcol_sq_b", int'(bus.square[0]), 1);
    check("wcol_st_b", int'(bus.strobe[0]), 0);
    @(posedge clock_in);
    #1;
    check("wcol_sq_c", int'(bus.square[0]), 0);
    check("wcol_st_c", int'(bus.strobe[0]), 1);

    // resync and write together
    @(negedge clock_in);
    bus.resync = 1'b1;
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 2'd0;
    bus.wr_inc = 8'd64;
    @(posedge clock_in);
    #1;
    check("rsw_zero", int'({bus.strobe, bus.square}), 0);
    check("rsw_running", int'(bus.running), 1);
    @(negedge clock_in);
    bus.resync = 1'b0;
    bus.wr_en  = 1'b0;
    @(posedge clock_in);
    #1;
    check("rsw_sq_a", int'(bus.square[0]), 0);
    @(posedge clock_in);
    #1;
    check("rsw_sq_b", int'(bus.square[0]), 1);

    // out-of-range channel write is ignored
    write_inc(NUM_CH, 255);
    do_resync();
    check_ch0_pattern("badch", 8);

    // lock loss mid-RUN
    @(negedge clock_in);
    locked = 1'b0;
    @(posedge clock_in);
    #1;
    check("loss_n", int'(bus.running), 1);
    @(posedge clock_in);
    #1;
    check("loss_n1", int'(bus.running), 1);
    @(posedge clock_in);
    #1;
    check("loss_n2_run", int'(bus.running), 0);
    check("loss_n2_outs", int'({bus.strobe, bus.square}), 0);
    @(negedge clock_in);
    locked = 1'b1;
    wait_running(edges);
    check("relock_rise", edges, SETTLE + 3);
    check_ch0_pattern("relock", 4);

    // lock drop during SETTLE restarts the full settle
    @(negedge clock_in);
    locked = 1'b0;
    repeat (3) @(posedge clock_in);
    @(negedge clock_in);
    locked = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clock_in);
      #1;
      check("settle_pre", int'(bus.running), 0);
    end
    @(negedge clock_in);
    locked = 1'b0;
    for (int e = 8; e <= 10; e++) begin
      @(posedge clock_in);
      #1;
      check("settle_drop", int'(bus.running), 0);
    end
    @(negedge clock_in);
    locked = 1'b1;
    wait_running(edges);
    check("settle_restart", edges, SETTLE + 3);
    check_ch0_pattern("retained", 4);

    // asynchronous reset mid-RUN
    @(posedge clock_in);
    #3;
    resetb = 1'b0;
    #1;
    check("areset_running", int'(bus.running), 0);
    check("areset_outs", int'({bus.strobe, bus.square}), 0);
    @(negedge clock_in);
    @(negedge clock_in);
    resetb = 1'b1;
    wait_running(edges);
    check("post_reset_rise", edges, SETTLE + 3);
    nall = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clock_in);
      #1;
      if (bus.strobe != '0 || bus.square != '0) nall++;
    end
    check("inc_reverted", nall, 0);

    @(negedge clock_in);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end
endmodule
